towerplacer_datapath: RTL and testbench
=======================================

Name: towerplacer_datapath

Overview:
- Responder end of the tower-placer control interface. Consumes the one-hot command levels from the tower-placer controller and returns `valid`, `square_done`, `erase_square_done` and `tower_done`.
- Owns the cursor cell position and the placed-tower occupancy bitmap.
- Generates pixel writes (x, y, colour, plot) toward the VGA adapter for:
  - the cursor square outline,
  - erasing that outline,
  - the filled tower sprite.

Parameters:
- CELL_LOG2, 4, log2 of cell edge in pixels (CELL=16)
- GRID_COLS, 10, cells per row
- GRID_ROWS, 7, cells per column
- START_COL, 0, cursor column after top_left
- START_ROW, 0, cursor row after top_left
- SQUARE_COLOUR, 3'b110, cursor outline colour
- BG_COLOUR, 3'b000, erase colour
- TOWER_COLOUR, 3'b011, tower fill colour

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- top_left  in  1  load cursor to (START_COL, START_ROW)
- draw_square  in  1  draw cursor outline
- erase_square_down, erase_square_right, erase_square_tower  in  1 each  erase cursor outline
- move_down  in  1  step cursor down until a valid cell is reached
- move_right  in  1  step cursor right until a valid cell is reached
- move_down_wait, move_right_wait  in  1 each  idle hold; no action
- draw_tower  in  1  fill tower at cursor and mark the cell occupied
- path_blocked  in  1  combinational path-map lookup for (cell_col, cell_row); 1 = enemy path
- cell_col  out  4  cursor column
- cell_row  out  4  cursor row
- valid  out  1  move complete; cursor is on a free cell
- square_done, erase_square_done, tower_done  out  1 each  single-cycle completion pulses
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write enable
- tower_placed  out  1  one-cycle pulse when the bitmap bit is set

Behaviour:

Reset (asynchronous, resetn=0):
- cursor = (START_COL, START_ROW).
- Bitmap cleared, pixel counter cleared, step flag cleared.
- x, y, colour, plot, all done pulses and tower_placed = 0.
- Reset mid-draw aborts the draw immediately. No done pulse is issued.

Cell origin:
- base_x = cell_col<<CELL_LOG2, base_y = cell_row<<CELL_LOG2.
- Widths are zero-extended and truncated to 8 and 7 bits.

top_left:
- Each cycle it is high, cursor loads (START_COL, START_ROW). Nothing is plotted.

Scan engine (draw_square, any erase_*, draw_tower):
- Counter k runs 0..N-1, N = CELL*CELL, incrementing once per cycle while the command is high.
- Pixel offsets: ox = k[CELL_LOG2-1:0], oy = k[2*CELL_LOG2-1:CELL_LOG2].
- Outputs are registered: pixel k appears on x/y/colour/plot in cycle k+1.
- Outline commands (draw_square, erase_*): plot=1 only on border pixels (ox or oy equal to 0 or CELL-1). Colour is SQUARE_COLOUR for draw, BG_COLOUR for erase.
- draw_tower: plot=1 only on interior pixels (not border). Colour is TOWER_COLOUR.
- Done timing: when k==N-1, the matching done output is registered high. It is therefore high in the same cycle pixel N-1 is on the outputs, for exactly one cycle.
- The counter returns to 0 on that cycle, and also whenever no scan command is high.
- If the command is still high after done, the scan restarts from k=0.

Tower commit:
- Coincident with tower_done, bitmap[cell_row*GRID_COLS+cell_col] is set and tower_placed pulses.

Validity:
- cell_ok = !path_blocked && !bitmap[cursor].

Moves (move_down / move_right):
- Step rules:
  - First cycle the command is high (step flag = 0): cursor steps unconditionally and the step flag is set.
  - Later cycles: if cell_ok, valid=1 (combinational: move active AND step flag AND cell_ok) and the cursor holds.
  - Otherwise the cursor steps again.
- Down step: row+1, wrapping GRID_ROWS-1 to 0; column unchanged.
- Right step: column+1, wrapping GRID_COLS-1 to 0; row unchanged.
- Termination: the origin cell was valid, so a move ends within GRID_ROWS (down) or GRID_COLS (right) steps.
- The step flag clears whenever neither move command is high. valid=0 outside moves.

Simultaneous commands:
- Priority: top_left > draw_tower > erase_* > draw_square > move_down > move_right.
- Lower-priority commands are ignored that cycle.
- wait commands and idle produce plot=0 and hold all state.

Test Plan:
- Outline count: reset, top_left 1 cycle, draw_square held → square_done pulses exactly once, 256 cycles after draw_square rises. Exactly 60 plot=1 cycles, colour=3'b110, x∈[0,15], y∈[0,15].
- Erase at (2,3): cursor at (2,3), erase_square_right held → 60 plotted pixels with colour 3'b000, x∈[32,47], y∈[48,63]. erase_square_done pulses once.
- Move skipping the path: cursor (0,0), path_blocked=1 for rows 1–2 of column 0, move_down held → cursor passes rows 1 and 2 and stops at (0,3). valid=1 on the 4th cycle of move_down.
- Row wrap: cursor (4,6), all cells free, move_down → cursor (4,0), valid on cycle 2. move_right from (9,0) → (0,0).
- Tower then occupancy: draw_tower at (1,0) → 196 interior pixels with colour 3'b011, tower_done and tower_placed coincide. A later move_right from (0,0) skips (1,0) and lands on (2,0).
- Async reset mid-scan: drop resetn at k=100 of draw_square → plot, x, y and square_done go 0 immediately. After release with draw_square held, the scan restarts at k=0.

Source files
------------

// File: rtl/towerplacer_datapath.sv
// Tower-placer datapath: cursor cell, occupancy bitmap and the pixel scan engine
// that draws/erases the cursor outline and fills tower sprites.
module towerplacer_datapath #(
  parameter int          CELL_LOG2     = 4,
  parameter int          GRID_COLS     = 10,
  parameter int          GRID_ROWS     = 7,
  parameter int          START_COL     = 0,
  parameter int          START_ROW     = 0,
  parameter logic [2:0]  SQUARE_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  TOWER_COLOUR  = 3'b011
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       top_left,
  input  logic       draw_square,
  input  logic       erase_square_down,
  input  logic       erase_square_right,
  input  logic       erase_square_tower,
  input  logic       move_down,
  input  logic       move_right,
  input  logic       move_down_wait,
  input  logic       move_right_wait,
  input  logic       draw_tower,
  input  logic       path_blocked,
  output logic [3:0] cell_col,
  output logic [3:0] cell_row,
  output logic       valid,
  output logic       square_done,
  output logic       erase_square_done,
  output logic       tower_done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       tower_placed
);

  localparam int KW    = 2 * CELL_LOG2;
  localparam int CELLS = GRID_COLS * GRID_ROWS;
  localparam int IW    = $clog2(CELLS);
  localparam logic [CELL_LOG2-1:0] EDGE = '1;

  logic [KW-1:0]        k;
  logic                 step;
  logic [CELLS-1:0]     bitmap;
  logic [IW-1:0]        idx;
  logic [CELL_LOG2-1:0] ox, oy;
  logic [7:0]           base_x;
  logic [6:0]           base_y;
  logic [3:0]           next_row, next_col;
  logic                 border, last, erase_any, scan_any, cell_ok;
  logic                 move_dn_act, move_rt_act;

  assign erase_any = erase_square_down | erase_square_right | erase_square_tower;
  assign scan_any  = draw_tower | erase_any | draw_square;

  assign ox     = k[CELL_LOG2-1:0];
  assign oy     = k[KW-1:CELL_LOG2];
  assign border = (ox == '0) || (ox == EDGE) || (oy == '0) || (oy == EDGE);
  assign last   = &k;

  assign base_x = 8'({cell_col, {CELL_LOG2{1'b0}}});
  assign base_y = 7'({cell_row, {CELL_LOG2{1'b0}}});

  assign idx     = IW'(cell_row) * IW'(GRID_COLS) + IW'(cell_col);
  assign cell_ok = !path_blocked && !bitmap[idx];

  assign next_row = (cell_row == 4'(GRID_ROWS - 1)) ? 4'd0 : cell_row + 4'd1;
  assign next_col = (cell_col == 4'(GRID_COLS - 1)) ? 4'd0 : cell_col + 4'd1;

  assign move_dn_act = move_down && !top_left && !scan_any;
  assign move_rt_act = move_right && !move_down && !top_left && !scan_any;
  assign valid       = (move_dn_act || move_rt_act) && step && cell_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cell_col          <= 4'(START_COL);
      cell_row          <= 4'(START_ROW);
      bitmap            <= '0;
      k                 <= '0;
      step              <= 1'b0;
      x                 <= '0;
      y                 <= '0;
      colour            <= '0;
      plot              <= 1'b0;
      square_done       <= 1'b0;
      erase_square_done <= 1'b0;
      tower_done        <= 1'b0;
      tower_placed      <= 1'b0;
    end else begin
      plot              <= 1'b0;
      square_done       <= 1'b0;
      erase_square_done <= 1'b0;
      tower_done        <= 1'b0;
      tower_placed      <= 1'b0;
      if (top_left) begin
        cell_col <= 4'(START_COL);
        cell_row <= 4'(START_ROW);
        k        <= '0;
        step     <= 1'b0;
      end else if (scan_any) begin
        // k wraps to 0 after the last pixel, so a held command rescans
        k    <= k + KW'(1);
        step <= 1'b0;
        x    <= base_x + 8'(ox);
        y    <= base_y + 7'(oy);
        if (draw_tower) begin
          plot   <= !border;
          colour <= TOWER_COLOUR;
          if (last) begin
            tower_done   <= 1'b1;
            tower_placed <= 1'b1;
            bitmap[idx]  <= 1'b1;
          end
        end else if (erase_any) begin
          plot              <= border;
          colour            <= BG_COLOUR;
          erase_square_done <= last;
        end else begin
          plot        <= border;
          colour      <= SQUARE_COLOUR;
          square_done <= last;
        end
      end else if (move_down || move_right) begin
        k    <= '0;
        step <= 1'b1;
        if (!step || !cell_ok) begin
          if (move_down) cell_row <= next_row;
          else           cell_col <= next_col;
        end
      end else if (move_down_wait || move_right_wait) begin
        k    <= '0;
        step <= 1'b0;
      end else begin
        k    <= '0;
        step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_towerplacer_datapath.sv
// Directed bench for towerplacer_datapath: vector table for single-cycle command
// decode and cursor moves, plus hand sequences for scans, wraps and reset.
module tb_towerplacer_datapath;

  logic       clk = 1'b0;
  logic       resetn;
  logic       top_left, draw_square, erase_square_down, erase_square_right;
  logic       erase_square_tower, move_down, move_right, move_down_wait;
  logic       move_right_wait, draw_tower, path_blocked;
  logic [3:0] cell_col, cell_row;
  logic       valid, square_done, erase_square_done, tower_done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, tower_placed;
  logic       path_en;

  int checks = 0;
  int failures = 0;

  towerplacer_datapath dut (
    .clk(clk), .resetn(resetn), .top_left(top_left), .draw_square(draw_square),
    .erase_square_down(erase_square_down), .erase_square_right(erase_square_right),
    .erase_square_tower(erase_square_tower), .move_down(move_down),
    .move_right(move_right), .move_down_wait(move_down_wait),
    .move_right_wait(move_right_wait), .draw_tower(draw_tower),
    .path_blocked(path_blocked), .cell_col(cell_col), .cell_row(cell_row),
    .valid(valid), .square_done(square_done), .erase_square_done(erase_square_done),
    .tower_done(tower_done), .x(x), .y(y), .colour(colour), .plot(plot),
    .tower_placed(tower_placed)
  );

  always #5 clk = ~clk;

  // Enemy path occupies column 0, rows 1 and 2
  always_comb path_blocked = path_en && (cell_col == 4'd0) && (cell_row == 4'd1 || cell_row == 4'd2);

  typedef struct {
    logic [5:0] cmd;   // {top_left, draw_square, move_down, move_right, move_down_wait, move_right_wait}
    logic       pen;
    logic       ev;
    logic [3:0] ecol;
    logic [3:0] erow;
    logic       eplot;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    if (sel == 0) return square_done;
    if (sel == 1) return erase_square_done;
    return tower_done;
  endfunction

  task automatic pulse_tl();
    top_left = 1'b1;
    @(posedge clk); #1;
    top_left = 1'b0;
  endtask

  task automatic do_move(input bit down, input int exp_cyc, input logic [3:0] ecol,
                         input logic [3:0] erow, input string nm);
    int  ncyc;
    bit  got;
    ncyc = 0;
    got  = 1'b0;
    move_down  = down;
    move_right = !down;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (valid) begin
        ncyc = i;
        got  = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_got_valid"}, 32'(got), 32'd1);
    if (exp_cyc > 0) chk({nm, "_cycles"}, 32'(ncyc), 32'(exp_cyc));
    chk({nm, "_col"}, 32'(cell_col), 32'(ecol));
    chk({nm, "_row"}, 32'(cell_row), 32'(erow));
    @(posedge clk); #1;
    move_down  = 1'b0;
    move_right = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_scan(input int sel, input logic [2:0] ecolour, input int xlo,
                          input int ylo, input int eplots, input string nm);
    int np, nd, dcyc;
    bit badc, badr, badtp;
    np = 0; nd = 0; dcyc = 0; badc = 0; badr = 0; badtp = 0;
    draw_square        = (sel == 0);
    erase_square_right = (sel == 1);
    draw_tower         = (sel == 2);
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (plot) begin
        np++;
        if (colour !== ecolour) badc = 1'b1;
        if (int'(x) < xlo || int'(x) > xlo + 15 || int'(y) < ylo || int'(y) > ylo + 15) badr = 1'b1;
      end
      if (done_of(sel)) begin
        nd++;
        dcyc = i;
      end
      if (tower_placed !== tower_done) badtp = 1'b1;
    end
    draw_square = 1'b0; erase_square_right = 1'b0; draw_tower = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_plots"}, 32'(np), 32'(eplots));
    chk({nm, "_colour_ok"}, 32'(badc), 32'd0);
    chk({nm, "_range_ok"}, 32'(badr), 32'd0);
    chk({nm, "_done_count"}, 32'(nd), 32'd1);
    chk({nm, "_done_cycle"}, 32'(dcyc), 32'd256);
    chk({nm, "_placed_with_done"}, 32'(badtp), 32'd0);
    chk({nm, "_done_after_release"}, 32'(done_of(sel)), 32'd0);
    chk({nm, "_plot_after_release"}, 32'(plot), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, dcyc;
    resetn = 1'b0;
    top_left = 0; draw_square = 0; erase_square_down = 0; erase_square_right = 0;
    erase_square_tower = 0; move_down = 0; move_right = 0; move_down_wait = 0;
    move_right_wait = 0; draw_tower = 0; path_en = 0;

    vt[0]  = '{6'b100000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[1]  = '{6'b000100, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0};
    vt[2]  = '{6'b000100, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0};
    vt[3]  = '{6'b000001, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0};
    vt[4]  = '{6'b001000, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0};
    vt[5]  = '{6'b001000, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0};
    vt[6]  = '{6'b000000, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0};
    vt[7]  = '{6'b001100, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0};
    vt[8]  = '{6'b001100, 1'b0, 1'b1, 4'd1, 4'd2, 1'b0};
    vt[9]  = '{6'b101000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[10] = '{6'b010100, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1};
    vt[11] = '{6'b000000, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
    vt[12] = '{6'b001000, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0};
    vt[13] = '{6'b001000, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0};
    vt[14] = '{6'b001000, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0};
    vt[15] = '{6'b001000, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0};
    vt[16] = '{6'b000000, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_col", 32'(cell_col), 32'd0);
    chk("reset_row", 32'(cell_row), 32'd0);
    chk("reset_plot", 32'(plot), 32'd0);
    chk("reset_xy", {16'd0, x, 1'b0, y}, 32'd0);
    chk("reset_colour", 32'(colour), 32'd0);
    chk("reset_dones", {28'd0, square_done, erase_square_done, tower_done, tower_placed}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      {top_left, draw_square, move_down, move_right, move_down_wait, move_right_wait} = vt[i].cmd;
      path_en = vt[i].pen;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vt[i].ev));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_col", i), 32'(cell_col), 32'(vt[i].ecol));
      chk($sformatf("vec%0d_row", i), 32'(cell_row), 32'(vt[i].erow));
      chk($sformatf("vec%0d_plot", i), 32'(plot), 32'(vt[i].eplot));
    end
    {top_left, draw_square, move_down, move_right, move_down_wait, move_right_wait} = 6'b0;
    path_en = 1'b0;
    @(posedge clk); #1;

    pulse_tl();
    run_scan(0, 3'b110, 0, 0, 60, "outline");

    pulse_tl();
    do_move(1'b0, 2, 4'd1, 4'd0, "to23_r1");
    do_move(1'b0, 2, 4'd2, 4'd0, "to23_r2");
    do_move(1'b1, 2, 4'd2, 4'd1, "to23_d1");
    do_move(1'b1, 2, 4'd2, 4'd2, "to23_d2");
    do_move(1'b1, 2, 4'd2, 4'd3, "to23_d3");
    run_scan(1, 3'b000, 32, 48, 60, "erase23");

    do_move(1'b0, 2, 4'd3, 4'd3, "to46_r1");
    do_move(1'b0, 2, 4'd4, 4'd3, "to46_r2");
    do_move(1'b1, 2, 4'd4, 4'd4, "to46_d1");
    do_move(1'b1, 2, 4'd4, 4'd5, "to46_d2");
    do_move(1'b1, 2, 4'd4, 4'd6, "to46_d3");
    do_move(1'b1, 2, 4'd4, 4'd0, "row_wrap");
    for (int c = 5; c <= 9; c++) do_move(1'b0, 2, 4'(c), 4'd0, $sformatf("to90_%0d", c));
    do_move(1'b0, 2, 4'd0, 4'd0, "col_wrap");

    pulse_tl();
    do_move(1'b0, 2, 4'd1, 4'd0, "to10");
    run_scan(2, 3'b011, 16, 0, 196, "tower10");
    pulse_tl();
    do_move(1'b0, 3, 4'd2, 4'd0, "skip_tower");

    pulse_tl();
    draw_square = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_x", 32'(x), 32'd0);
    chk("rst_mid_y", 32'(y), 32'd0);
    chk("rst_mid_done", 32'(square_done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    nd = 0; dcyc = 0;
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("restart_x0", 32'(x), 32'd0);
        chk("restart_y0", 32'(y), 32'd0);
        chk("restart_plot0", 32'(plot), 32'd1);
      end
      if (i == 2) chk("restart_x1", 32'(x), 32'd1);
      if (square_done) begin
        nd++;
        dcyc = i;
      end
    end
    draw_square = 1'b0;
    @(posedge clk); #1;
    chk("restart_done_count", 32'(nd), 32'd1);
    chk("restart_done_cycle", 32'(dcyc), 32'd256);
    do_move(1'b0, 2, 4'd1, 4'd0, "bitmap_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
